// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - CPU run/step/halt controller with prescaled clock-enable and optional breakpoint
//
// Generates a one-cycle clock-enable (cpuTick) for a CPU core from a
// power-of-two prescaler. The core can be free-running (RUN), advanced by a
// single tick (STEP), halted (HALT) or stopped at a breakpoint (BRK).
//
// Optional feature: define SM_RUN_CTRL_BREAKPOINT_EN to compile in the
// pc/bpAddr breakpoint compare. Without it pc, bpAddr and bpEnable are ignored
// and BRK is never entered.
//
// Ports:
//   clkIn      in   1  clock, all state changes on its rising edge
//   rst_n      in   1  asynchronous active-low reset
//   devide     in   4  period exponent offset, tick period = 2^(SHIFT+devide)
//   runReq     in   1  run request (rising edge, pre-synchronized)
//   stepReq    in   1  single-step request (rising edge, pre-synchronized)
//   haltReq    in   1  halt request (level, highest priority)
//   pc         in  32  current CPU instruction address
//   bpAddr     in  32  breakpoint address
//   bpEnable   in   1  breakpoint enable
//   cpuTick    out  1  registered one-cycle CPU clock-enable pulse
//   state      out  2  HALT=00 RUN=01 STEP=10 BRK=11
//   halted     out  1  high in HALT or BRK
//   tickCount  out 32  number of cpuTick pulses issued (wraps)
module sm_run_ctrl #(
  parameter int SHIFT = 16
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic [3:0]  devide,
  input  logic        runReq,
  input  logic        stepReq,
  input  logic        haltReq,
  input  logic [31:0] pc,
  input  logic [31:0] bpAddr,
  input  logic        bpEnable,
  output logic        cpuTick,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] tickCount
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_t;

  localparam int CW = SHIFT + 16;

  state_t          state_q, state_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [CW-1:0]   tick_mask;
  logic [31:0]     sh;
  logic            run_q, step_q;
  logic            armed_q;
  logic            exempt_q, exempt_nxt;
  logic            tick_nxt;
  logic            pre_tick;
  logic            bp_hit;
  logic            run_edge, step_edge;

  // armed_q keeps the first clock after reset as a pure sampling cycle, so a
  // request that is already high when reset releases is not seen as an edge.
  assign run_edge  = armed_q && runReq  && !run_q;
  assign step_edge = armed_q && stepReq && !step_q;

  // Tick when the low SHIFT+devide counter bits are all ones; devide is used
  // live, so a change simply moves the compare window without a restart.
  assign sh        = SHIFT + 32'(devide);
  assign tick_mask = ~({CW{1'b1}} << sh);
  assign pre_tick  = (cnt_q & tick_mask) == tick_mask;

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  // exempt_q lets the first tick after leaving BRK through, so execution
  // can resume past the instruction that triggered the breakpoint.
  assign bp_hit = bpEnable && (pc == bpAddr) && !exempt_q;
`else
  logic bp_unused;
  assign bp_unused = ^{pc, bpAddr, bpEnable};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HALT;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      armed_q   <= 1'b0;
      exempt_q  <= 1'b0;
      cpuTick   <= 1'b0;
      tickCount <= '0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      run_q    <= runReq;
      step_q   <= stepReq;
      armed_q  <= 1'b1;
      exempt_q <= exempt_nxt;
      cpuTick  <= tick_nxt;
      if (tick_nxt) begin
        tickCount <= tickCount + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    exempt_nxt = exempt_q;
    tick_nxt   = 1'b0;

    if (state_q == ST_RUN || state_q == ST_STEP) begin
      cnt_nxt = cnt_q + CW'(1);
    end

    if (haltReq) begin
      state_nxt  = ST_HALT;
      exempt_nxt = 1'b0;
    end else begin
      case (state_q)
        ST_HALT, ST_BRK: begin
          // Run wins when both edges land in the same cycle.
          if (run_edge) begin
            state_nxt  = ST_RUN;
            cnt_nxt    = '0;
            exempt_nxt = (state_q == ST_BRK);
          end else if (step_edge) begin
            state_nxt  = ST_STEP;
            cnt_nxt    = '0;
            exempt_nxt = (state_q == ST_BRK);
          end
        end
        ST_RUN: begin
          if (pre_tick) begin
            exempt_nxt = 1'b0;
            if (bp_hit) begin
              state_nxt = ST_BRK;
            end else begin
              tick_nxt = 1'b1;
            end
          end
        end
        ST_STEP: begin
          // Leave STEP on the same edge that raises the single cpuTick.
          if (pre_tick) begin
            tick_nxt   = 1'b1;
            exempt_nxt = 1'b0;
            state_nxt  = ST_HALT;
          end
        end
        default: state_nxt = ST_HALT;
      endcase
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT) || (state_q == ST_BRK);

endmodule

// File: doc/sm_run_ctrl.md
SM_RUN_CTRL -- requirements
Module: sm_run_ctrl

Interface
REQ-001 Parameter SHIFT, default 16, base log2 of tick period in clkIn cycles.
REQ-002 Port clkIn  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port devide  input  4  period exponent offset; tick period = 2^(SHIFT+devide) cycles.
REQ-005 Port runReq  input  1  run request; rising edge acts.
REQ-006 Port stepReq  input  1  single-step request; rising edge acts.
REQ-007 Port haltReq  input  1  halt request; level acts.
REQ-008 Port pc  input  32  current CPU instruction address.
REQ-009 Port bpAddr  input  32  breakpoint address.
REQ-010 Port bpEnable  input  1  breakpoint enable.
REQ-011 Port cpuTick  output  1  one-cycle CPU clock-enable pulse.
REQ-012 Port state  output  2  HALT=00, RUN=01, STEP=10, BRK=11.
REQ-013 Port halted  output  1  high in HALT or BRK.
REQ-014 Port tickCount  output  32  number of cpuTick pulses issued.

Function
REQ-015 runReq, stepReq SHALL be already synchronized externally; edge = current AND NOT registered previous value.
REQ-016 Prescaler counter SHALL be SHIFT+16 bits, increment every cycle in RUN/STEP, clear to 0 on entry to RUN or STEP.
REQ-017 Prescaler tick SHALL assert when low SHIFT+devide counter bits are all ones; a devide change applies from the next cycle, no counter reset.
REQ-018 cpuTick SHALL be registered: high for exactly the cycle after a prescaler tick in RUN/STEP, unless suppressed (REQ-023).
REQ-019 HALT: runReq edge -> RUN; else stepReq edge -> STEP; simultaneous edges -> RUN.
REQ-020 RUN: haltReq high -> HALT, no further cpuTick; haltReq has priority over every other event in every state.
REQ-021 STEP: issues exactly one cpuTick, first tick 2^(SHIFT+devide) cycles after entry, then -> HALT in the same cycle cpuTick asserts.
REQ-022 BRK: runReq edge -> RUN; else stepReq edge -> STEP; simultaneous -> RUN.
REQ-023 Breakpoint (when compiled in): in RUN, prescaler tick with bpEnable=1 and pc==bpAddr SHALL suppress cpuTick and enter BRK.
REQ-024 First prescaler tick after leaving BRK SHALL be exempt from breakpoint check, allowing resume past the breakpoint.
REQ-025 Run/step edges arriving in RUN or STEP SHALL be ignored.
REQ-026 tickCount SHALL increment by 1 per cpuTick, wrapping 2^32-1 -> 0.
REQ-027 halted SHALL be combinational decode of state.

Reset
REQ-028 rst_n low SHALL immediately force state=HALT, cpuTick=0, halted=1, tickCount=0, prescaler=0, edge registers=0, exemption flag=0.
REQ-029 Reset mid-RUN or mid-STEP SHALL abort with no pending tick after release.
REQ-030 First edge evaluation SHALL occur on first rising clkIn after rst_n deasserts; an input already high at release is not an edge.

Configuration
REQ-031 Macro SM_RUN_CTRL_BREAKPOINT_EN defined: REQ-023/REQ-024 active.
REQ-032 Macro undefined: pc, bpAddr, bpEnable ignored; BRK never entered; all other behaviour identical.

Verification (SHIFT=2, devide=0, period 4, macro defined unless noted)
REQ-033 Reset release, runReq pulse -> state=01, cpuTick pulses every 4 cycles, first 4 cycles after entry; tickCount=5 after 5 pulses.
REQ-034 From HALT, stepReq pulse -> exactly one cpuTick, state back to 00, tickCount=1; second step -> tickCount=2.
REQ-035 RUN, bpEnable=1, bpAddr=pc=0x0000_0010 -> no cpuTick, state=11, halted=1; runReq pulse -> next tick issued, state=01.
REQ-036 RUN with haltReq and stepReq edge same cycle -> state=00, no further cpuTick; devide 0->2 in RUN -> period becomes 16.
REQ-037 rst_n low mid-RUN at tickCount=3 -> tickCount=0, state=00, cpuTick=0 immediately; macro undefined with bp match -> ticks continue, state stays 01.
REQ-038 tickCount forced/preloaded to 0xFFFF_FFFF, one step -> tickCount=0x0000_0000.
